// File: rtl/code_line_filler.sv
// Line-fill engine between the code cache and SDRAM: aligns a miss to its line, issues one
// read per word with bounded outstanding reads, and streams returned words to the cache in order.
`timescale 1ns/1ps
module code_line_filler #(
    parameter int ADDR_W          = 23,
    parameter int LINE_WORDS      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    input  logic [ADDR_W-1:0]             miss_addr,
    output logic                          miss_ready,
    output logic                          sdram_req_valid,
    input  logic                          sdram_req_ready,
    output logic [ADDR_W-1:0]             sdram_req_addr,
    input  logic                          sdram_rd_valid,
    input  logic [31:0]                   sdram_rd_data,
    output logic                          fill_valid,
    output logic [31:0]                   fill_data,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic                          fill_done
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic              fill_valid_q, fill_valid_d;
    logic [31:0]       fill_data_q, fill_data_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;

    logic [CNT_W-1:0]  outstanding;
    logic              issue_fire;
    logic              rd_accept;
    logic              last_word;

    // Reads return in command order, so the in-flight count is just the difference of counters.
    assign outstanding = issue_cnt_q - recv_cnt_q;

    assign miss_ready      = (state_q == IDLE);
    assign fill_done       = (state_q == DONE);
    assign sdram_req_valid = (state_q == FILL)
                           && (issue_cnt_q < CNT_W'(LINE_WORDS))
                           && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign sdram_req_addr  = base_q + ADDR_W'({issue_cnt_q, 2'b00});

    assign issue_fire = sdram_req_valid && sdram_req_ready;
    // Returns outside FILL or with nothing in flight are protocol errors and are dropped.
    assign rd_accept  = sdram_rd_valid && (state_q == FILL) && (outstanding != '0);
    assign last_word  = (recv_cnt_q == CNT_W'(LINE_WORDS - 1));

    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign fill_idx   = fill_idx_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        fill_valid_d = 1'b0;
        fill_data_d  = fill_data_q;
        fill_idx_d   = fill_idx_q;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    base_d      = {miss_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (rd_accept) begin
                    fill_valid_d = 1'b1;
                    fill_data_d  = sdram_rd_data;
                    fill_idx_d   = recv_cnt_q[IDX_W-1:0];
                    recv_cnt_d   = recv_cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= '0;
            fill_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            fill_valid_q <= fill_valid_d;
            fill_data_q  <= fill_data_d;
            fill_idx_q   <= fill_idx_d;
        end
    end

endmodule
